// File: rtl/matmul_seq_pkg.sv
// matmul_seq_pkg: shared state encoding and timing constants for the matmul sequencer
package matmul_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;
  localparam int CLEAR_CYCLES = 1;
  localparam int TIMEOUT_MULT = 3;
endpackage

// File: rtl/matmul_row_buf.sv
// matmul_row_buf: row-wide buffer with one write port and one registered read port
module matmul_row_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  // write a row, and look up the requested row (out-of-range rows read as zero)
  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_addr <= LAST) mem_d[wr_addr] = wr_data;
    rd_valid_d = rd_en;
    rd_data_d  = (rd_en && rd_addr <= LAST) ? mem_q[rd_addr] : '0;
  end
  // storage and read registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads A/B, clears and feeds a systolic array, collects C; MATMUL_SEQ_TIMEOUT_EN adds a DRAIN watchdog
module matmul_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ld_valid,
  input  logic                              ld_sel,
  input  logic [$clog2(N_SIZE)-1:0]         ld_row,
  input  logic [N_SIZE*DATAWIDTH-1:0]       ld_data,
  output logic                              ld_ready,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              sa_rst_n,
  output logic                              sa_valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0]       sa_a_out,
  output logic [N_SIZE*DATAWIDTH-1:0]       sa_b_out,
  input  logic                              sa_valid_out,
  input  logic [N_SIZE*2*DATAWIDTH-1:0]     sa_c_in,
  input  logic                              rd_en,
  input  logic [$clog2(N_SIZE)-1:0]         rd_row,
  output logic                              rd_valid,
  output logic [N_SIZE*2*DATAWIDTH-1:0]     rd_data
);
  localparam int RW  = $clog2(N_SIZE);
  localparam int RWD = N_SIZE * DATAWIDTH;
  localparam logic [RW-1:0] LAST     = RW'(N_SIZE - 1);
  localparam logic [RW-1:0] CLR_LAST = RW'(CLEAR_CYCLES - 1);
  state_e         state_q, state_d;
  logic [RW-1:0]  t_q, t_d, r_q, r_d;
  logic [RWD-1:0] a_q [N_SIZE];
  logic [RWD-1:0] a_d [N_SIZE];
  logic [RWD-1:0] b_q [N_SIZE];
  logic [RWD-1:0] b_d [N_SIZE];
  logic [RWD-1:0] sa_a_q, sa_a_d, sa_b_q, sa_b_d;
  logic           sa_rst_n_q, sa_rst_n_d, sa_valid_q, sa_valid_d;
  logic           busy_q, busy_d, done_q, done_d, ld_ready_q, ld_ready_d;
  logic           feed, cap, last_cap;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_MULT * N_SIZE);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_MULT * N_SIZE - 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d, tmo;
`endif
  // operand loads, FSM sequencing and next values of the registered array-side outputs
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    r_d      = r_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_a_d   = '0;
    cap      = (state_q == S_DRAIN) && sa_valid_out;
    last_cap = cap && (r_q == LAST);
`ifdef MATMUL_SEQ_TIMEOUT_EN
    wd_d = '0;
    tmo  = 1'b0;
`endif
    if (state_q == S_IDLE && ld_valid && ld_row <= LAST) begin
      if (ld_sel) b_d[ld_row] = ld_data;
      else a_d[ld_row] = ld_data;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          t_d     = '0;
        end
      end
      S_CLEAR: begin
        t_d     = (t_q == CLR_LAST) ? '0 : t_q + RW'(1);
        state_d = (t_q == CLR_LAST) ? S_FEED : S_CLEAR;
      end
      S_FEED: begin
        t_d     = (t_q == LAST) ? t_q : t_q + RW'(1);
        r_d     = '0;
        state_d = (t_q == LAST) ? S_DRAIN : S_FEED;
      end
      S_DRAIN: begin
        r_d = cap ? r_q + RW'(1) : r_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        wd_d = wd_q + WW'(1);
        tmo  = (wd_q == WLAST);
`endif
        if (last_cap) state_d = S_DONE;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        else if (tmo) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    feed = (state_d == S_FEED);
    for (int i = 0; i < N_SIZE; i++)
      sa_a_d[i*DATAWIDTH +: DATAWIDTH] = feed ? a_q[i][int'(t_d)*DATAWIDTH +: DATAWIDTH] : '0;
    sa_b_d     = feed ? b_q[t_d] : '0;
    sa_valid_d = feed;
    sa_rst_n_d = (state_d != S_CLEAR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    ld_ready_d = (state_d == S_IDLE);
`ifdef MATMUL_SEQ_TIMEOUT_EN
    err_d = tmo && !last_cap;
`endif
  end
  // state, operand buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      r_q        <= '0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      sa_a_q     <= '0;
      sa_b_q     <= '0;
      sa_valid_q <= 1'b0;
      sa_rst_n_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_ready_q <= 1'b1;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      r_q        <= r_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sa_a_q     <= sa_a_d;
      sa_b_q     <= sa_b_d;
      sa_valid_q <= sa_valid_d;
      sa_rst_n_q <= sa_rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ld_ready_q <= ld_ready_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end
  matmul_row_buf #(
    .WIDTH(N_SIZE * 2 * DATAWIDTH),
    .DEPTH(N_SIZE)
  ) u_c_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap),
    .wr_addr (r_q),
    .wr_data (sa_c_in),
    .rd_en   (rd_en),
    .rd_addr (rd_row),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );
  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sa_rst_n    = sa_rst_n_q;
  assign sa_valid_in = sa_valid_q;
  assign sa_a_out    = sa_a_q;
  assign sa_b_out    = sa_b_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench with a behavioural systolic array for matmul_sequencer
module tb_matmul_sequencer;
  localparam int N  = 5;
  localparam int DW = 16;
  typedef logic [159:0] w_t;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ld_valid = 1'b0, ld_sel = 1'b0;
  logic [2:0]         ld_row = '0;
  logic [N*DW-1:0]    ld_data = '0;
  logic               ld_ready;
  logic               start = 1'b0;
  logic               busy, done, err;
  logic               sa_rst_n, sa_valid_in;
  logic [N*DW-1:0]    sa_a_out, sa_b_out;
  logic               sa_valid_out = 1'b0;
  logic [2*N*DW-1:0]  sa_c_in = '0;
  logic               rd_en = 1'b0;
  logic [2:0]         rd_row = '0;
  logic               rd_valid;
  logic [2*N*DW-1:0]  rd_data;
  int                 n_tests = 0, n_fail = 0;
  int                 ta [N][N];
  int                 tbm [N][N];
  logic [31:0]        acc [N][N];

  matmul_sequencer #(.DATAWIDTH(DW), .N_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .busy(busy), .done(done), .err(err),
    .sa_rst_n(sa_rst_n), .sa_valid_in(sa_valid_in), .sa_a_out(sa_a_out), .sa_b_out(sa_b_out),
    .sa_valid_out(sa_valid_out), .sa_c_in(sa_c_in),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  // behavioural output-stationary array: clears on sa_rst_n, accumulates outer products
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (!sa_rst_n) acc[i][j] <= '0;
        else if (sa_valid_in)
          acc[i][j] <= acc[i][j] + 32'(sa_a_out[i*DW +: DW]) * 32'(sa_b_out[j*DW +: DW]);

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] acol(int t);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'(ta[i][t]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] brow(int t);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = 16'(tbm[t][j]);
    return v;
  endfunction

  function automatic logic [2*N*DW-1:0] crow(int r);
    logic [2*N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*32 +: 32] = acc[r][j];
    return v;
  endfunction

  function automatic logic [2*N*DW-1:0] fill(int x);
    logic [2*N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*32 +: 32] = 32'(x);
    return v;
  endfunction

  function automatic logic [2*N*DW-1:0] seqrow(int r);
    logic [2*N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*32 +: 32] = 32'(r * 5 + j);
    return v;
  endfunction

  task automatic load(input logic s, input int r, input logic [N*DW-1:0] d);
    check("ld_ready_idle", w_t'(ld_ready), 1);
    ld_valid = 1'b1; ld_sel = s; ld_row = 3'(r); ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
    if (r < N)
      for (int j = 0; j < N; j++)
        if (s) tbm[r][j] = int'(d[j*DW +: DW]);
        else ta[r][j] = int'(d[j*DW +: DW]);
  endtask

  task automatic read_row(input int r, input logic [2*N*DW-1:0] exp);
    rd_en = 1'b1; rd_row = 3'(r);
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_valid", w_t'(rd_valid), 1);
    check($sformatf("rd_row%0d", r), w_t'(rd_data), w_t'(exp));
  endtask

  // one job: start (optionally with a row-2 load), check CLEAR/FEED, drain rows or stall
  task automatic run_job(input bit ld_now, input bit poke, input bit stall);
    int k;
    start = 1'b1;
    if (ld_now) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 3'd2; ld_data = {N{16'd2}};
      for (int j = 0; j < N; j++) ta[2][j] = 2;
    end
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    check("clr_busy", w_t'(busy), 1);
    check("clr_sa_rst_n", w_t'(sa_rst_n), 0);
    check("clr_valid", w_t'(sa_valid_in), 0);
    check("clr_ld_ready", w_t'(ld_ready), 0);
    @(negedge clk);
    for (int t = 0; t < N; t++) begin
      check("feed_valid", w_t'(sa_valid_in), 1);
      check("feed_sa_rst_n", w_t'(sa_rst_n), 1);
      check($sformatf("feed_a_t%0d", t), w_t'(sa_a_out), w_t'(acol(t)));
      check($sformatf("feed_b_t%0d", t), w_t'(sa_b_out), w_t'(brow(t)));
      if (poke && t == 1) begin
        ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 3'd0; ld_data = {N{16'hFFFF}};
        check("feed_ld_ready", w_t'(ld_ready), 0);
      end
      @(negedge clk);
      ld_valid = 1'b0;
    end
    check("drain_valid", w_t'(sa_valid_in), 0);
    check("drain_a_zero", w_t'(sa_a_out), 0);
    check("drain_b_zero", w_t'(sa_b_out), 0);
    if (stall) begin
`ifdef MATMUL_SEQ_TIMEOUT_EN
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done) break;
      end
      check("tmo_cycles", w_t'(k), 15);
      check("tmo_err", w_t'(err), 1);
      check("tmo_done", w_t'(done), 1);
      @(negedge clk);
      check("tmo_done_drop", w_t'(done), 0);
      check("tmo_idle", w_t'(busy), 0);
      return;
`else
      repeat (20) @(negedge clk);
      check("stall_busy", w_t'(busy), 1);
      check("stall_done", w_t'(done), 0);
      check("stall_err", w_t'(err), 0);
`endif
    end
    for (int r = 0; r < N; r++) begin
      check("drain_no_done", w_t'(done), 0);
      sa_valid_out = 1'b1; sa_c_in = crow(r);
      @(negedge clk);
    end
    sa_valid_out = 1'b0; sa_c_in = '0;
    check("done_pulse", w_t'(done), 1);
    check("done_err", w_t'(err), 0);
    check("done_busy", w_t'(busy), 1);
    @(negedge clk);
    check("done_drop", w_t'(done), 0);
    check("idle_busy", w_t'(busy), 0);
    check("idle_ld_ready", w_t'(ld_ready), 1);
  endtask

  initial begin
    logic [N*DW-1:0] d;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_busy", w_t'(busy), 0);
    check("rst_done", w_t'(done), 0);
    check("rst_err", w_t'(err), 0);
    check("rst_rd_valid", w_t'(rd_valid), 0);
    check("rst_sa_valid", w_t'(sa_valid_in), 0);
    check("rst_sa_rst_n", w_t'(sa_rst_n), 0);
    check("rst_sa_a", w_t'(sa_a_out), 0);
    check("rst_sa_b", w_t'(sa_b_out), 0);
    check("rst_rd_data", w_t'(rd_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sa_rst_n", w_t'(sa_rst_n), 1);
    read_row(0, '0);
    // identity times sequential B gives B back
    for (int i = 0; i < N; i++) begin
      d = '0;
      d[i*DW +: DW] = 16'd1;
      load(1'b0, i, d);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) d[j*DW +: DW] = 16'(i * 5 + j);
      load(1'b1, i, d);
    end
    load(1'b1, 7, {N{16'hDEAD}});
    run_job(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) read_row(r, seqrow(r));
    read_row(7, '0);
    // all ones, two jobs in a row: no accumulation across jobs
    for (int i = 0; i < N; i++) load(1'b0, i, {N{16'd1}});
    for (int i = 0; i < N; i++) load(1'b1, i, {N{16'd1}});
    run_job(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) read_row(r, fill(5));
    run_job(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < N; r++) read_row(r, fill(5));
    // load attempted during FEED is dropped
    run_job(1'b0, 1'b1, 1'b0);
    read_row(0, fill(5));
    run_job(1'b0, 1'b0, 1'b0);
    read_row(0, fill(5));
    // load together with start feeds the new row
    run_job(1'b1, 1'b0, 1'b0);
    read_row(2, fill(10));
    read_row(1, fill(5));
    // stalled drain: watchdog or indefinite wait, C keeps prior job values
    run_job(1'b0, 1'b0, 1'b1);
    read_row(2, fill(10));
    // reset in the third FEED cycle aborts the job
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_feed", w_t'(sa_valid_in), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", w_t'(busy), 0);
    check("abort_done", w_t'(done), 0);
    check("abort_sa_rst_n", w_t'(sa_rst_n), 0);
    check("abort_sa_valid", w_t'(sa_valid_in), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", w_t'(seen), 0);
    check("abort_idle", w_t'(busy), 0);
    for (int r = 0; r < N; r++) read_row(r, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DATAWIDTH, 16, element width of A and B.
REQ-002 SHALL have parameter N_SIZE, 5, square matrix dimension (>=2).
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ld_valid in 1, ld_sel in 1 (0=A, 1=B), ld_row in $clog2(N_SIZE), ld_data in N_SIZE*DATAWIDTH, ld_ready out 1: operand load port.
REQ-006 SHALL have ports start in 1, busy out 1, done out 1, err out 1: job control.
REQ-007 SHALL have ports sa_rst_n out 1, sa_valid_in out 1, sa_a_out out N_SIZE*DATAWIDTH, sa_b_out out N_SIZE*DATAWIDTH: array drive side.
REQ-008 SHALL have ports sa_valid_out in 1, sa_c_in in N_SIZE*2*DATAWIDTH: array result side.
REQ-009 SHALL have ports rd_en in 1, rd_row in $clog2(N_SIZE), rd_valid out 1, rd_data out N_SIZE*2*DATAWIDTH: result read port.

Function
REQ-010 SHALL implement FSM IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-011 In IDLE, ld_ready=1; an ld_valid beat writes ld_data into row ld_row of A (ld_sel=0) or B (ld_sel=1); ld_row >= N_SIZE is ignored.
REQ-012 Outside IDLE, ld_ready=0 and ld_valid is ignored.
REQ-013 start sampled high in IDLE moves to CLEAR; start in any other state is ignored.
REQ-014 CLEAR lasts exactly 1 cycle with registered sa_rst_n=0; sa_rst_n=1 in all other states.
REQ-015 FEED lasts exactly N_SIZE cycles, t=0..N_SIZE-1, with sa_valid_in=1, element i of sa_a_out = A[i][t], element j of sa_b_out = B[t][j].
REQ-016 Outside FEED, sa_valid_in=0 and sa_a_out = sa_b_out = 0.
REQ-017 DRAIN captures sa_c_in into C row r on each cycle sa_valid_out=1, r counting 0..N_SIZE-1; it leaves for DONE the cycle after row N_SIZE-1 is captured.
REQ-018 sa_valid_out in IDLE, CLEAR or FEED is ignored.
REQ-019 DONE lasts 1 cycle: done=1; then IDLE.
REQ-020 busy=1 in CLEAR, FEED, DRAIN and DONE; 0 in IDLE.
REQ-021 A 1-cycle rd_en pulse in any state gives rd_valid=1 and rd_data = C[rd_row] on the next cycle; rd_row >= N_SIZE returns 0 with rd_valid=1.
REQ-022 C rows not yet overwritten in the current job hold previous job values.
REQ-023 A, B and C buffers are retained across jobs; a job may start with no new loads.
REQ-024 ld_valid and start in the same IDLE cycle: the load is written and the FSM enters CLEAR, so FEED uses the new data.

Reset
REQ-025 rst_n low SHALL force IDLE, clear A/B/C and counters, and set busy=done=err=rd_valid=sa_valid_in=0, sa_a_out=sa_b_out=rd_data=0, sa_rst_n=0 while asserted.
REQ-026 Reset mid-job SHALL abort the job with no done pulse.

Configuration
REQ-027 Macro MATMUL_SEQ_TIMEOUT_EN SHALL gate the DRAIN watchdog.
REQ-028 With the macro defined, DRAIN exceeding 3*N_SIZE cycles SHALL end in DONE with done=1 and err=1 for that cycle.
REQ-029 Without the macro, DRAIN waits indefinitely, and err SHALL be tied to 0.

Structure
REQ-030 Package matmul_seq_pkg SHALL hold the state enum and the CLEAR_CYCLES=1 and TIMEOUT_MULT=3 constants.
REQ-031 Sub-module matmul_row_buf (parameterised row-width buffer, 1 write port, 1 registered read port) SHALL implement the C buffer; A and B stay inline for column extraction.

Verification (N_SIZE=5, DATAWIDTH=16, connected to the systolic array)
REQ-032 A=identity, B[i][j]=i*5+j, start -> done once; rd_row 0..4 returns C=B; err=0.
REQ-033 A[i][j]=B[i][j]=1, start twice back-to-back -> each job reads C all 5s; the second job shows no accumulation of the first.
REQ-034 Load during FEED (ld_valid=1, value 0xFFFF) -> ld_ready=0; next job still uses the old data.
REQ-035 rst_n pulsed low in the 3rd FEED cycle -> busy=0, no done; rd_data=0 for all rows.
REQ-036 With MATMUL_SEQ_TIMEOUT_EN defined and sa_valid_out held 0 -> done=err=1 exactly 15 cycles after DRAIN entry.
REQ-037 start with ld_valid on row 2 of A in the same cycle -> C row 2 reflects the new row.
